// File: rtl/id_ex_if.sv
// ID -> EX stage bus: decoded instruction from ID, registered ID_EX_* fields,
// pipeline write enables and the load-use hazard status.
interface id_ex_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DATA_WIDTH = 32,
  parameter int CNT_WIDTH      = 32
);
  logic                      flush;
  logic                      ext_stall;
  logic                      ID_valid;
  logic                      ID_uses_rs1;
  logic                      ID_uses_rs2;
  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1;
  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2;
  logic [REG_ADDR_WIDTH-1:0] ID_rd;
  logic                      ID_RegWrite;
  logic                      ID_MemRead;
  logic                      ID_MemWrite;
  logic                      ID_ALUSrc;
  logic [3:0]                ID_ALUOp;
  logic [REG_DATA_WIDTH-1:0] ID_rs1_data;
  logic [REG_DATA_WIDTH-1:0] ID_rs2_data;
  logic [REG_DATA_WIDTH-1:0] ID_imm;
  logic [REG_DATA_WIDTH-1:0] ID_pc;

  logic                      ID_EX_valid;
  logic [REG_ADDR_WIDTH-1:0] ID_EX_rs1;
  logic [REG_ADDR_WIDTH-1:0] ID_EX_rs2;
  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd;
  logic                      ID_EX_RegWrite;
  logic                      ID_EX_MemRead;
  logic                      ID_EX_MemWrite;
  logic                      ID_EX_ALUSrc;
  logic [3:0]                ID_EX_ALUOp;
  logic [REG_DATA_WIDTH-1:0] ID_EX_rs1_data;
  logic [REG_DATA_WIDTH-1:0] ID_EX_rs2_data;
  logic [REG_DATA_WIDTH-1:0] ID_EX_imm;
  logic [REG_DATA_WIDTH-1:0] ID_EX_pc;
  logic                      PC_write;
  logic                      IF_ID_write;
  logic                      load_use_stall;
  logic [CNT_WIDTH-1:0]      stall_count;

  // Handshake: there is no valid/ready pair here. ID_valid qualifies the ID
  // fields every cycle; PC_write/IF_ID_write low means "upstream must hold",
  // and ID_EX_valid qualifies the registered fields seen by EX.
  modport master (
    output flush, ext_stall, ID_valid, ID_uses_rs1, ID_uses_rs2,
           IF_ID_rs1, IF_ID_rs2, ID_rd, ID_RegWrite, ID_MemRead,
           ID_MemWrite, ID_ALUSrc, ID_ALUOp, ID_rs1_data, ID_rs2_data,
           ID_imm, ID_pc,
    input  ID_EX_valid, ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_RegWrite,
           ID_EX_MemRead, ID_EX_MemWrite, ID_EX_ALUSrc, ID_EX_ALUOp,
           ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm, ID_EX_pc,
           PC_write, IF_ID_write, load_use_stall, stall_count
  );

  modport slave (
    input  flush, ext_stall, ID_valid, ID_uses_rs1, ID_uses_rs2,
           IF_ID_rs1, IF_ID_rs2, ID_rd, ID_RegWrite, ID_MemRead,
           ID_MemWrite, ID_ALUSrc, ID_ALUOp, ID_rs1_data, ID_rs2_data,
           ID_imm, ID_pc,
    output ID_EX_valid, ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_RegWrite,
           ID_EX_MemRead, ID_EX_MemWrite, ID_EX_ALUSrc, ID_EX_ALUOp,
           ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm, ID_EX_pc,
           PC_write, IF_ID_write, load_use_stall, stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, one-bubble stall
// insertion, flush and downstream-stall hold, plus a saturating bubble counter.
module id_ex_stage #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DATA_WIDTH = 32,
  parameter int CNT_WIDTH      = 32
) (
  input logic   clk,
  input logic   rst_n,
  id_ex_if.slave bus
);
  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic                      alu_src;
    logic [3:0]                alu_op;
    logic [REG_DATA_WIDTH-1:0] rs1_data;
    logic [REG_DATA_WIDTH-1:0] rs2_data;
    logic [REG_DATA_WIDTH-1:0] imm;
    logic [REG_DATA_WIDTH-1:0] pc;
  } id_ex_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  id_ex_t               ex_q, ex_d, id_capture;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
  logic                 hz;
  logic                 load_use_stall;
  logic                 hold_upstream;

  // A load in EX whose destination is read by the instruction in ID.
  always_comb begin
    hz = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & bus.ID_valid &
         ((bus.ID_uses_rs1 & (ex_q.rd == bus.IF_ID_rs1)) |
          (bus.ID_uses_rs2 & (ex_q.rd == bus.IF_ID_rs2)));
    load_use_stall = hz & ~bus.flush & ~bus.ext_stall;
    // Flush redirects fetch, so it always releases the front end.
    hold_upstream  = rst_n & ~bus.flush & (bus.ext_stall | load_use_stall);
  end

  always_comb begin
    id_capture.valid     = 1'b1;
    id_capture.rs1       = bus.IF_ID_rs1;
    id_capture.rs2       = bus.IF_ID_rs2;
    id_capture.rd        = bus.ID_rd;
    id_capture.reg_write = bus.ID_RegWrite;
    id_capture.mem_read  = bus.ID_MemRead;
    id_capture.mem_write = bus.ID_MemWrite;
    id_capture.alu_src   = bus.ID_ALUSrc;
    id_capture.alu_op    = bus.ID_ALUOp;
    id_capture.rs1_data  = bus.ID_rs1_data;
    id_capture.rs2_data  = bus.ID_rs2_data;
    id_capture.imm       = bus.ID_imm;
    id_capture.pc        = bus.ID_pc;
  end

  always_comb begin
    ex_d          = ex_q;
    stall_count_d = stall_count_q;
    if (bus.flush) begin
      ex_d = '0;
    end else if (bus.ext_stall) begin
      ex_d = ex_q;
    end else if (load_use_stall) begin
      ex_d = '0;
      if (stall_count_q != '1) stall_count_d = stall_count_q + CNT_ONE;
    end else if (bus.ID_valid) begin
      ex_d = id_capture;
    end else begin
      ex_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q          <= '0;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.ID_EX_valid    = ex_q.valid;
  assign bus.ID_EX_rs1      = ex_q.rs1;
  assign bus.ID_EX_rs2      = ex_q.rs2;
  assign bus.ID_EX_rd       = ex_q.rd;
  assign bus.ID_EX_RegWrite = ex_q.reg_write;
  assign bus.ID_EX_MemRead  = ex_q.mem_read;
  assign bus.ID_EX_MemWrite = ex_q.mem_write;
  assign bus.ID_EX_ALUSrc   = ex_q.alu_src;
  assign bus.ID_EX_ALUOp    = ex_q.alu_op;
  assign bus.ID_EX_rs1_data = ex_q.rs1_data;
  assign bus.ID_EX_rs2_data = ex_q.rs2_data;
  assign bus.ID_EX_imm      = ex_q.imm;
  assign bus.ID_EX_pc       = ex_q.pc;
  assign bus.PC_write       = ~hold_upstream;
  assign bus.IF_ID_write    = ~hold_upstream;
  assign bus.load_use_stall = load_use_stall;
  assign bus.stall_count    = stall_count_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and random stimulus for id_ex_stage, checked every cycle against a
// behavioural pipeline-register model plus hand-computed literal expectations.
module tb_id_ex_stage;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_if #(.CNT_WIDTH(32)) bus  ();
  id_ex_if #(.CNT_WIDTH(2))  bus2 ();

  id_ex_stage #(.CNT_WIDTH(32)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  id_ex_stage #(.CNT_WIDTH(2))  u_sat (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus2.flush       = bus.flush;
  assign bus2.ext_stall   = bus.ext_stall;
  assign bus2.ID_valid    = bus.ID_valid;
  assign bus2.ID_uses_rs1 = bus.ID_uses_rs1;
  assign bus2.ID_uses_rs2 = bus.ID_uses_rs2;
  assign bus2.IF_ID_rs1   = bus.IF_ID_rs1;
  assign bus2.IF_ID_rs2   = bus.IF_ID_rs2;
  assign bus2.ID_rd       = bus.ID_rd;
  assign bus2.ID_RegWrite = bus.ID_RegWrite;
  assign bus2.ID_MemRead  = bus.ID_MemRead;
  assign bus2.ID_MemWrite = bus.ID_MemWrite;
  assign bus2.ID_ALUSrc   = bus.ID_ALUSrc;
  assign bus2.ID_ALUOp    = bus.ID_ALUOp;
  assign bus2.ID_rs1_data = bus.ID_rs1_data;
  assign bus2.ID_rs2_data = bus.ID_rs2_data;
  assign bus2.ID_imm      = bus.ID_imm;
  assign bus2.ID_pc       = bus.ID_pc;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid = 1'b0;
  logic [4:0]  m_rs1 = '0, m_rs2 = '0, m_rd = '0;
  logic        m_rw = 1'b0, m_mr = 1'b0, m_mw = 1'b0, m_as = 1'b0;
  logic [3:0]  m_op = '0;
  logic [31:0] m_d1 = '0, m_d2 = '0, m_imm = '0, m_pc = '0;
  int unsigned m_cnt = 0;

  task automatic model_bubble();
    m_valid = 1'b0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
    m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_as = 1'b0; m_op = '0;
    m_d1 = '0; m_d2 = '0; m_imm = '0; m_pc = '0;
  endtask

  function automatic logic model_hazard();
    logic reads_rd;
    reads_rd = (bus.ID_uses_rs1 && m_rd == bus.IF_ID_rs1) ||
               (bus.ID_uses_rs2 && m_rd == bus.IF_ID_rs2);
    return m_valid && m_mr && m_rd != 0 && bus.ID_valid && reads_rd;
  endfunction

  function automatic logic exp_stall();
    return model_hazard() && !bus.flush && !bus.ext_stall;
  endfunction

  function automatic logic exp_write_en();
    if (!rst_n || bus.flush) return 1'b1;
    return !(bus.ext_stall || exp_stall());
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_bubble();
      m_cnt = 0;
    end else if (bus.flush) begin
      model_bubble();
    end else if (bus.ext_stall) begin
      // contents held
    end else if (model_hazard()) begin
      model_bubble();
      m_cnt = m_cnt + 1;
    end else if (!bus.ID_valid) begin
      model_bubble();
    end else begin
      m_valid = 1'b1; m_rs1 = bus.IF_ID_rs1; m_rs2 = bus.IF_ID_rs2; m_rd = bus.ID_rd;
      m_rw = bus.ID_RegWrite; m_mr = bus.ID_MemRead; m_mw = bus.ID_MemWrite;
      m_as = bus.ID_ALUSrc; m_op = bus.ID_ALUOp;
      m_d1 = bus.ID_rs1_data; m_d2 = bus.ID_rs2_data; m_imm = bus.ID_imm; m_pc = bus.ID_pc;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("id_ex_regs",
        {bus.ID_EX_valid, bus.ID_EX_rs1, bus.ID_EX_rs2, bus.ID_EX_rd, bus.ID_EX_RegWrite,
         bus.ID_EX_MemRead, bus.ID_EX_MemWrite, bus.ID_EX_ALUSrc, bus.ID_EX_ALUOp,
         bus.ID_EX_rs1_data, bus.ID_EX_rs2_data, bus.ID_EX_imm, bus.ID_EX_pc},
        {m_valid, m_rs1, m_rs2, m_rd, m_rw, m_mr, m_mw, m_as, m_op, m_d1, m_d2, m_imm, m_pc});
    chk("hazard_flags", {bus.PC_write, bus.IF_ID_write, bus.load_use_stall},
        {exp_write_en(), exp_write_en(), exp_stall()});
    chk("stall_count", bus.stall_count, m_cnt);
    chk("stall_count_sat", bus2.stall_count, (m_cnt > 3) ? 3 : m_cnt);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic u1, input logic u2,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic [3:0] op);
    bus.ID_valid    = v;
    bus.ID_uses_rs1 = u1;
    bus.ID_uses_rs2 = u2;
    bus.IF_ID_rs1   = rs1;
    bus.IF_ID_rs2   = rs2;
    bus.ID_rd       = rd;
    bus.ID_RegWrite = rw;
    bus.ID_MemRead  = mr;
    bus.ID_MemWrite = 1'b0;
    bus.ID_ALUSrc   = mr;
    bus.ID_ALUOp    = op;
    bus.ID_rs1_data = $urandom;
    bus.ID_rs2_data = $urandom;
    bus.ID_imm      = $urandom;
    bus.ID_pc       = $urandom;
  endtask

  task automatic drive_random(input int max_idx);
    drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, max_idx)), 5'($urandom_range(0, max_idx)),
          5'($urandom_range(0, max_idx)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    bus.ID_MemWrite = 1'($urandom_range(0, 1));
  endtask

  logic [31:0] held_pc;
  logic [31:0] new_pc;

  initial begin
    // Reset with random inputs
    bus.flush = 1'b1;
    bus.ext_stall = 1'b1;
    drive_random(31);
    tick();
    tick();
    chk("reset_regs", {bus.ID_EX_valid, bus.ID_EX_rd, bus.ID_EX_MemRead, bus.ID_EX_pc}, '0);
    chk("reset_write_en", {bus.PC_write, bus.IF_ID_write}, 2'b11);
    chk("reset_count", bus.stall_count, 0);
    bus.flush = 1'b0;
    bus.ext_stall = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // Load-use: lw x5 then add x6,x5,x1
    drive(1, 1, 0, 5'd2, 5'd0, 5'd5, 1, 1, 4'd0);
    tick();
    drive(1, 1, 1, 5'd5, 5'd1, 5'd6, 1, 0, 4'd2);
    settle();
    chk("lu_stall_flag", bus.load_use_stall, 1'b1);
    chk("lu_pc_write", {bus.PC_write, bus.IF_ID_write}, 2'b00);
    tick();
    chk("lu_bubble", bus.ID_EX_valid, 1'b0);
    chk("lu_released", bus.load_use_stall, 1'b0);
    tick();
    chk("lu_capture_rs1", {bus.ID_EX_valid, bus.ID_EX_rs1, bus.ID_EX_rd}, {1'b1, 5'd5, 5'd6});
    chk("lu_count", bus.stall_count, 1);

    // No false stall: lw x0 then reader of x0
    drive(1, 1, 0, 5'd3, 5'd0, 5'd0, 1, 1, 4'd0);
    tick();
    drive(1, 1, 0, 5'd0, 5'd0, 5'd7, 1, 0, 4'd1);
    settle();
    chk("rd0_no_stall", bus.load_use_stall, 1'b0);
    tick();
    chk("rd0_capture", {bus.ID_EX_valid, bus.ID_EX_rd}, {1'b1, 5'd7});
    // lw x5 then consumer whose rs2 field matches but is unused
    drive(1, 1, 0, 5'd3, 5'd0, 5'd5, 1, 1, 4'd0);
    tick();
    drive(1, 1, 0, 5'd3, 5'd5, 5'd8, 1, 0, 4'd1);
    settle();
    chk("unused_rs2_no_stall", {bus.load_use_stall, bus.PC_write}, 2'b01);
    tick();
    chk("unused_rs2_capture", {bus.ID_EX_valid, bus.ID_EX_rd}, {1'b1, 5'd8});

    // Flush beats hazard
    drive(1, 1, 0, 5'd3, 5'd0, 5'd5, 1, 1, 4'd0);
    tick();
    drive(1, 1, 0, 5'd5, 5'd0, 5'd9, 1, 0, 4'd1);
    bus.flush = 1'b1;
    settle();
    chk("flush_flags", {bus.load_use_stall, bus.PC_write, bus.IF_ID_write}, 3'b011);
    tick();
    bus.flush = 1'b0;
    chk("flush_bubble", bus.ID_EX_valid, 1'b0);
    chk("flush_count", bus.stall_count, 1);

    // ext_stall hold for 3 cycles
    drive(1, 1, 1, 5'd1, 5'd2, 5'd10, 1, 0, 4'd3);
    held_pc = bus.ID_pc;
    tick();
    bus.ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_random(31);
      settle();
      chk("ext_stall_pc_write", {bus.PC_write, bus.IF_ID_write}, 2'b00);
      tick();
      chk("ext_stall_hold", {bus.ID_EX_pc, bus.ID_EX_rd}, {held_pc, 5'd10});
    end
    bus.ext_stall = 1'b0;
    drive(1, 1, 1, 5'd1, 5'd2, 5'd11, 1, 0, 4'd4);
    new_pc = bus.ID_pc;
    tick();
    chk("ext_stall_release", {bus.ID_EX_pc, bus.ID_EX_rd}, {new_pc, 5'd11});

    // Dependent load chain: lw x5; lw x6,0(x5); add x7,x6
    drive(1, 1, 0, 5'd1, 5'd0, 5'd5, 1, 1, 4'd0);
    tick();
    drive(1, 1, 0, 5'd5, 5'd0, 5'd6, 1, 1, 4'd0);
    tick();
    tick();
    drive(1, 1, 0, 5'd6, 5'd0, 5'd7, 1, 0, 4'd1);
    tick();
    tick();
    chk("chain_count", bus.stall_count, 3);

    // Five load-use events: 2-bit counter saturates
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 5'd1, 5'd0, 5'd7, 1, 1, 4'd0);
      tick();
      drive(1, 0, 1, 5'd0, 5'd7, 5'd8, 1, 0, 4'd1);
      tick();
      tick();
    end
    chk("sat_count", bus2.stall_count, 2'd3);
    chk("wide_count", bus.stall_count, 8);

    // Reset in the middle of a load-use stall
    drive(1, 1, 0, 5'd1, 5'd0, 5'd9, 1, 1, 4'd0);
    tick();
    drive(1, 1, 0, 5'd9, 5'd0, 5'd12, 1, 0, 4'd1);
    settle();
    chk("mid_reset_stall", bus.load_use_stall, 1'b1);
    rst_n = 1'b0;
    settle();
    chk("mid_reset_clear", {bus.ID_EX_valid, bus.stall_count, bus.PC_write}, {1'b0, 32'd0, 1'b1});
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_capture", {bus.ID_EX_valid, bus.ID_EX_rs1, bus.ID_EX_rd, bus.stall_count},
        {1'b1, 5'd9, 5'd12, 32'd0});

    // Random traffic with small register indices so hazards are frequent
    for (int i = 0; i < 300; i++) begin
      bus.flush     = ($urandom_range(0, 9) == 0);
      bus.ext_stall = ($urandom_range(0, 7) == 0);
      drive_random(3);
      tick();
    end
    bus.flush = 1'b0;
    bus.ext_stall = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection, stall and flush control.
- Captures decoded control and operands from ID and presents the ID_EX_* fields consumed by the EX stage and the forwarding unit (rd, rs1, rs2, RegWrite, MemRead).
- Inserts one bubble on a load-use dependency, since forwarding cannot cover it.
- Freezes PC and IF/ID during that bubble.

Parameters:
REG_ADDR_WIDTH, 5, register index width
REG_DATA_WIDTH, 32, register/operand data width
CNT_WIDTH, 32, width of the load-use stall counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  branch/jump taken in EX; kill the instruction entering ID/EX
ext_stall  input  1  downstream (MEM) wait; hold ID/EX contents
ID_valid  input  1  ID holds a real instruction
ID_uses_rs1  input  1  instruction in ID reads rs1
ID_uses_rs2  input  1  instruction in ID reads rs2
IF_ID_rs1  input  REG_ADDR_WIDTH  rs1 index in ID
IF_ID_rs2  input  REG_ADDR_WIDTH  rs2 index in ID
ID_rd  input  REG_ADDR_WIDTH  destination index in ID
ID_RegWrite  input  1  decoded control
ID_MemRead  input  1  decoded control
ID_MemWrite  input  1  decoded control
ID_ALUSrc  input  1  decoded control
ID_ALUOp  input  4  decoded ALU operation
ID_rs1_data  input  REG_DATA_WIDTH  register-file read data 1
ID_rs2_data  input  REG_DATA_WIDTH  register-file read data 2
ID_imm  input  REG_DATA_WIDTH  sign-extended immediate
ID_pc  input  REG_DATA_WIDTH  PC of instruction in ID
ID_EX_valid  output  1  registered valid
ID_EX_rs1, ID_EX_rs2, ID_EX_rd  output  REG_ADDR_WIDTH each  registered indices
ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_ALUSrc  output  1 each  registered control
ID_EX_ALUOp  output  4  registered ALU operation
ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm, ID_EX_pc  output  REG_DATA_WIDTH each  registered data
PC_write  output  1  combinational; 0 freezes PC
IF_ID_write  output  1  combinational; 0 freezes IF/ID
load_use_stall  output  1  combinational hazard flag
stall_count  output  CNT_WIDTH  number of load-use bubbles inserted

Behaviour:
Reset:
- rst_n low asynchronously clears every registered output and stall_count to 0 (state is a bubble).
- PC_write and IF_ID_write are 1 during reset.

Hazard detection (combinational):
- hz = ID_EX_valid & ID_EX_MemRead & (ID_EX_rd != 0) & ID_valid & ((ID_uses_rs1 & ID_EX_rd == IF_ID_rs1) | (ID_uses_rs2 & ID_EX_rd == IF_ID_rs2)).
- load_use_stall = hz & ~flush & ~ext_stall.

Per-edge update priority: flush > ext_stall > load_use_stall > normal.
- flush: load bubble. Bubble = valid, RegWrite, MemRead, MemWrite, ALUSrc, ALUOp all 0; rd, rs1, rs2 = 0; data fields don't-care, implemented as 0. PC_write = 1, IF_ID_write = 1 (flush overrides stalls).
- ext_stall (no flush): all ID/EX registers hold. PC_write = 0, IF_ID_write = 0. No bubble; counter holds.
- load_use_stall: load bubble. PC_write = 0, IF_ID_write = 0. stall_count += 1, saturating at all ones.
- Normal: capture all ID_* inputs. If ID_valid = 0, capture as bubble (control forced 0). PC_write = 1, IF_ID_write = 1.

Latency and timing:
- Latency ID -> ID_EX_* is 1 cycle.
- A load-use dependency costs exactly 1 bubble. On the next cycle ID_EX_MemRead = 0, so hz drops and the dependent instruction advances; the load's result is then forwarded from MEM/WB.
- rd = 0 never stalls.
- Back-to-back loads with a dependency chain produce one bubble per dependent pair.
- Deasserting rst_n mid-stall aborts it; the first post-reset edge behaves as normal.

Test Plan:
- Reset: rst_n = 0 with random inputs -> all outputs 0, stall_count 0, PC_write = IF_ID_write = 1.
- Load-use: lw x5 in ID/EX, add x6,x5,x1 in ID (uses both) -> load_use_stall = 1, PC_write = 0, next cycle ID_EX_valid = 0. Following cycle add captured with ID_EX_rs1 = 5, stall_count = 1.
- No false stall: lw x0 in ID/EX with rs1 = 0, or lw x5 with consumer having ID_uses_rs2 = 0 and rs2 = 5 -> no stall, capture normally.
- Flush vs hazard: hazard present and flush = 1 -> bubble loaded, PC_write = 1, stall_count unchanged.
- ext_stall: hold 3 cycles with changing ID inputs -> ID_EX_* constant, PC_write = 0. Release -> capture current ID inputs.
- Saturation: CNT_WIDTH = 2, five consecutive load-use events -> stall_count stays at 3.
